// File: rtl/unaligned_access_sequencer.sv
// Splits unaligned MEM-stage accesses into aligned data-memory accesses and stalls the pipeline meanwhile.
// Optional UNALIGNED_TRAP_EN: unaligned accesses raise an address-error trap instead of being split.
package unaligned_access_sequencer_pkg;
  typedef enum logic [2:0] {
    READ_BYTE_SIGNED   = 3'd0,
    READ_BYTE_UNSIGNED = 3'd1,
    READ_HALF_SIGNED   = 3'd2,
    READ_HALF_UNSIGNED = 3'd3,
    READ_WORD          = 3'd4
  } read_type_t;

  typedef enum logic [1:0] {
    WRITE_BYTE = 2'd0,
    WRITE_HALF = 2'd1,
    WRITE_WORD = 2'd2
  } write_type_t;
endpackage

module unaligned_access_sequencer
  import unaligned_access_sequencer_pkg::*;
#(
  parameter logic [4:0] LOAD_EXC_CODE  = 5'd4,
  parameter logic [4:0] STORE_EXC_CODE = 5'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqLoad,
  input  logic        reqWriteEnable,
  input  logic [31:0] reqAddress,
  input  read_type_t  reqReadType,
  input  write_type_t reqWriteType,
  input  logic [31:0] reqWriteValue,
  input  logic [31:0] reqPc,
  output logic        stall,
  output logic [31:0] loadResult,
  output logic        exceptionValid,
  output logic [4:0]  exceptionCode,
  output logic [31:0] memAddress,
  output read_type_t  memReadType,
  output logic        memWriteEnable,
  output write_type_t memWriteType,
  output logic [31:0] memWriteValue,
  output logic [31:0] memPcValue,
  input  logic [31:0] memReadResult
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_HI    = 2'd1,
    STORE_BEAT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] lowWord;
  logic [1:0]  beat;

  logic        isStore;
  logic        isLoad;
  logic        isWord;
  logic        isHalf;
  logic        unaligned;
  logic [1:0]  lastBeat;
  logic [1:0]  curBeat;
  logic [31:0] alignedBase;
  logic [31:0] merged;
  logic [7:0]  storeByte;
  logic        stallS;
  logic        writeEnableS;
  logic        exceptionS;
  logic [31:0] loadS;

`ifndef UNALIGNED_TRAP_EN
  logic [9:0]  unusedExcCodes;
  assign unusedExcCodes = {LOAD_EXC_CODE, STORE_EXC_CODE};
`endif

  function automatic logic [31:0] extendHalf(input logic [15:0] half, input logic signedExt);
    return signedExt ? {{16{half[15]}}, half} : {16'd0, half};
  endfunction

  // Classify the request and precompute addresses, merge window and the store byte for the current beat.
  always_comb begin
    isStore     = reqWriteEnable;
    isLoad      = reqLoad & ~reqWriteEnable;
    isWord      = isStore ? (reqWriteType == WRITE_WORD) : (reqReadType == READ_WORD);
    isHalf      = isStore ? (reqWriteType == WRITE_HALF)
                          : ((reqReadType == READ_HALF_SIGNED) || (reqReadType == READ_HALF_UNSIGNED));
    unaligned   = reqValid & (isStore | isLoad) &
                  ((isWord & (reqAddress[1:0] != 2'b00)) | (isHalf & reqAddress[0]));
    lastBeat    = isWord ? 2'd3 : 2'd1;
    curBeat     = (state == STORE_BEAT) ? beat : 2'd0;
    alignedBase = {reqAddress[31:2], 2'b00};
    merged      = 32'({memReadResult, lowWord} >> {reqAddress[1:0], 3'b000});
    storeByte   = reqWriteValue[{curBeat, 3'b000} +: 8];
  end

  // Drive the memory side and the pipeline-facing results for the current state.
  always_comb begin
    memAddress    = reqAddress;
    memReadType   = reqReadType;
    memWriteType  = reqWriteType;
    memWriteValue = reqWriteValue;
    memPcValue    = reqPc;
    writeEnableS  = reqValid & reqWriteEnable;
    stallS        = 1'b0;
    exceptionS    = 1'b0;
    exceptionCode = 5'd0;
    loadS         = memReadResult;
    case (state)
      IDLE: begin
        if (unaligned) begin
`ifdef UNALIGNED_TRAP_EN
          writeEnableS  = 1'b0;
          exceptionS    = 1'b1;
          exceptionCode = isStore ? STORE_EXC_CODE : LOAD_EXC_CODE;
          loadS         = 32'd0;
`else
          stallS = 1'b1;
          if (isStore) begin
            writeEnableS  = 1'b1;
            memWriteType  = WRITE_BYTE;
            memWriteValue = {24'd0, storeByte};
          end else begin
            memAddress  = alignedBase;
            memReadType = READ_WORD;
          end
`endif
        end else begin
          stallS = 1'b0;
        end
      end
      LOAD_HI: begin
        writeEnableS = 1'b0;
        memAddress   = alignedBase + 32'd4;
        memReadType  = READ_WORD;
        if (isWord) begin
          loadS = merged;
        end else begin
          loadS = extendHalf(merged[15:0], reqReadType == READ_HALF_SIGNED);
        end
      end
      STORE_BEAT: begin
        writeEnableS  = 1'b1;
        memWriteType  = WRITE_BYTE;
        memAddress    = reqAddress + {30'd0, beat};
        memWriteValue = {24'd0, storeByte};
        stallS        = (beat != lastBeat);
      end
      default: begin
        writeEnableS = 1'b0;
      end
    endcase
  end

  // Reset forces the pipeline-facing controls quiet even before the first clock edge.
  assign stall          = reset & stallS;
  assign memWriteEnable = reset & writeEnableS;
  assign exceptionValid = reset & exceptionS;
  assign loadResult     = reset ? loadS : 32'd0;

  // Sequencer state: low-word capture for split loads, beat counter for split stores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lowWord <= 32'd0;
      beat    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
`ifdef UNALIGNED_TRAP_EN
          state <= IDLE;
`else
          if (unaligned && isStore) begin
            state <= STORE_BEAT;
            beat  <= 2'd1;
          end else if (unaligned) begin
            lowWord <= memReadResult;
            state   <= LOAD_HI;
          end else begin
            state <= IDLE;
          end
`endif
        end
        LOAD_HI: begin
          state <= IDLE;
        end
        STORE_BEAT: begin
          if (beat == lastBeat) begin
            state <= IDLE;
            beat  <= 2'd0;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          beat  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unaligned_access_sequencer.sv
// Self-checking bench for unaligned_access_sequencer with a byte-array reference model.
module tb_unaligned_access_sequencer;
  import unaligned_access_sequencer_pkg::*;

`ifdef UNALIGNED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqLoad;
  logic        reqWriteEnable;
  logic [31:0] reqAddress;
  read_type_t  reqReadType;
  write_type_t reqWriteType;
  logic [31:0] reqWriteValue;
  logic [31:0] reqPc;
  logic        stall;
  logic [31:0] loadResult;
  logic        exceptionValid;
  logic [4:0]  exceptionCode;
  logic [31:0] memAddress;
  read_type_t  memReadType;
  logic        memWriteEnable;
  write_type_t memWriteType;
  logic [31:0] memWriteValue;
  logic [31:0] memPcValue;
  logic [31:0] memReadResult;

  int nChecks = 0;
  int nFail   = 0;

  logic [7:0] mem    [64];
  logic [7:0] refMem [64];

  logic [31:0] obsAddr  [8];
  logic [31:0] obsWval  [8];
  logic        obsStall [8];
  logic        obsWe    [8];
  write_type_t obsWt    [8];
  int          obsCycles;
  logic [31:0] obsLoad;
  logic        obsExc;
  logic [4:0]  obsCode;
  logic [31:0] obsPc;

  unaligned_access_sequencer dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqLoad(reqLoad),
    .reqWriteEnable(reqWriteEnable), .reqAddress(reqAddress), .reqReadType(reqReadType),
    .reqWriteType(reqWriteType), .reqWriteValue(reqWriteValue), .reqPc(reqPc),
    .stall(stall), .loadResult(loadResult), .exceptionValid(exceptionValid),
    .exceptionCode(exceptionCode), .memAddress(memAddress), .memReadType(memReadType),
    .memWriteEnable(memWriteEnable), .memWriteType(memWriteType), .memWriteValue(memWriteValue),
    .memPcValue(memPcValue), .memReadResult(memReadResult)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Data memory: 64 bytes aliased over the address space, reads extended per read type.
  always_comb begin
    memReadResult = 32'd0;
    case (memReadType)
      READ_WORD:          memReadResult = {mem[{memAddress[5:2], 2'd3}], mem[{memAddress[5:2], 2'd2}],
                                           mem[{memAddress[5:2], 2'd1}], mem[{memAddress[5:2], 2'd0}]};
      READ_HALF_SIGNED:   memReadResult = {{16{mem[{memAddress[5:1], 1'b1}][7]}},
                                           mem[{memAddress[5:1], 1'b1}], mem[{memAddress[5:1], 1'b0}]};
      READ_HALF_UNSIGNED: memReadResult = {16'd0, mem[{memAddress[5:1], 1'b1}], mem[{memAddress[5:1], 1'b0}]};
      READ_BYTE_SIGNED:   memReadResult = {{24{mem[memAddress[5:0]][7]}}, mem[memAddress[5:0]]};
      READ_BYTE_UNSIGNED: memReadResult = {24'd0, mem[memAddress[5:0]]};
      default:            memReadResult = 32'd0;
    endcase
  end

  always @(posedge clock) begin
    if (memWriteEnable) begin
      case (memWriteType)
        WRITE_BYTE: mem[memAddress[5:0]] <= memWriteValue[7:0];
        WRITE_HALF: begin
          mem[{memAddress[5:1], 1'b0}] <= memWriteValue[7:0];
          mem[{memAddress[5:1], 1'b1}] <= memWriteValue[15:8];
        end
        WRITE_WORD: begin
          mem[{memAddress[5:2], 2'd0}] <= memWriteValue[7:0];
          mem[{memAddress[5:2], 2'd1}] <= memWriteValue[15:8];
          mem[{memAddress[5:2], 2'd2}] <= memWriteValue[23:16];
          mem[{memAddress[5:2], 2'd3}] <= memWriteValue[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int accessSize(input bit st, input read_type_t rt, input write_type_t wt);
    if (st) return (wt == WRITE_WORD) ? 4 : ((wt == WRITE_HALF) ? 2 : 1);
    return (rt == READ_WORD) ? 4 : (((rt == READ_HALF_SIGNED) || (rt == READ_HALF_UNSIGNED)) ? 2 : 1);
  endfunction

  function automatic bit misaligned(input logic [31:0] addr, input int size);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input read_type_t rt);
    int size = accessSize(1'b0, rt, WRITE_BYTE);
    logic [31:0] v = 32'd0;
    bit sgn = (rt == READ_HALF_SIGNED) || (rt == READ_BYTE_SIGNED);
    for (int i = 0; i < size; i++) v = v | (32'(refMem[(addr + 32'(i)) % 64]) << (8 * i));
    if (sgn && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  function automatic int modelCycles(input bit st, input logic [31:0] addr, input int size);
    if (!misaligned(addr, size) || TRAP) return 1;
    return st ? size : 2;
  endfunction

  task automatic modelStore(input logic [31:0] addr, input int size, input logic [31:0] wv);
    for (int i = 0; i < size; i++) refMem[(addr + 32'(i)) % 64] = wv[8 * i +: 8];
  endtask

  function automatic logic [31:0] memWord(input int idx);
    return {mem[4 * idx + 3], mem[4 * idx + 2], mem[4 * idx + 1], mem[4 * idx]};
  endfunction

  // ---------------- stimulus ----------------
  task automatic preload();
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      mem[i]    <= b;
      refMem[i] = b;
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]        <= 8'(32'h44332211 >> (8 * i));
      refMem[i]     = 8'(32'h44332211 >> (8 * i));
      mem[4 + i]    <= 8'(32'h887766F5 >> (8 * i));
      refMem[4 + i] = 8'(32'h887766F5 >> (8 * i));
    end
    #1;
  endtask

  // Drives one request starting just after a rising edge and records what the DUT showed each cycle.
  task automatic runAccess(input bit st, input logic [31:0] addr, input read_type_t rt,
                           input write_type_t wt, input logic [31:0] wv);
    reqValid       = 1'b1;
    reqLoad        = !st;
    reqWriteEnable = st;
    reqAddress     = addr;
    reqReadType    = rt;
    reqWriteType   = wt;
    reqWriteValue  = wv;
    reqPc          = $urandom;
    obsCycles      = 99;
    for (int c = 0; c < 8; c++) begin
      #3;
      obsAddr[c]  = memAddress;
      obsWval[c]  = memWriteValue;
      obsStall[c] = stall;
      obsWe[c]    = memWriteEnable;
      obsWt[c]    = memWriteType;
      obsLoad     = loadResult;
      obsExc      = exceptionValid;
      obsCode     = exceptionCode;
      obsPc       = memPcValue;
      if (!stall) begin
        obsCycles = c + 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    reqValid       = 1'b0;
    reqLoad        = 1'b0;
    reqWriteEnable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; reqValid = 1'b1; reqLoad = 1'b0; reqWriteEnable = 1'b1;
    reqAddress = 32'h1; reqReadType = READ_WORD; reqWriteType = WRITE_WORD;
    reqWriteValue = 32'hDEADBEEF; reqPc = 32'h100;
    #2;
    nChecks++;
    if ({stall, memWriteEnable, exceptionValid} !== 3'b000 || loadResult !== 32'd0) begin
      nFail++;
      $display("FAIL reset_outputs: stall=%b we=%b exc=%b load=%h, required 0 0 0 00000000",
               stall, memWriteEnable, exceptionValid, loadResult);
    end
    reqValid = 1'b0; reqWriteEnable = 1'b0;
    preload();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    #3;
    nChecks++;
    if (stall !== 1'b0 || memWriteEnable !== 1'b0) begin
      nFail++;
      $display("FAIL idle_after_reset: stall=%b we=%b, required 0 0", stall, memWriteEnable);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_plan_loads();
    runAccess(1'b0, 32'h4, READ_WORD, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsCycles != 1 || obsLoad !== 32'h887766F5) begin
      nFail++;
      $display("FAIL aligned_load: cycles=%0d load=%h, required 1 887766F5", obsCycles, obsLoad);
    end
    runAccess(1'b0, 32'h1, READ_WORD, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsCycles != (TRAP ? 1 : 2) || obsLoad !== (TRAP ? 32'd0 : 32'hF5443322) ||
        obsExc !== TRAP || obsCode !== (TRAP ? 5'd4 : 5'd0)) begin
      nFail++;
      $display("FAIL word_load_0x1: cycles=%0d load=%h exc=%b code=%0d, required %0d %h %b %0d",
               obsCycles, obsLoad, obsExc, obsCode, TRAP ? 1 : 2,
               TRAP ? 32'd0 : 32'hF5443322, TRAP, TRAP ? 4 : 0);
    end
    nChecks++;
    if (!TRAP && (obsAddr[0] !== 32'h0 || obsStall[0] !== 1'b1 || obsAddr[1] !== 32'h4)) begin
      nFail++;
      $display("FAIL word_load_addr: a0=%h s0=%b a1=%h, required 00000000 1 00000004",
               obsAddr[0], obsStall[0], obsAddr[1]);
    end
    runAccess(1'b0, 32'h3, READ_HALF_SIGNED, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsCycles != (TRAP ? 1 : 2) || obsLoad !== (TRAP ? 32'd0 : 32'hFFFFF544)) begin
      nFail++;
      $display("FAIL half_signed_0x3: cycles=%0d load=%h, required %0d %h",
               obsCycles, obsLoad, TRAP ? 1 : 2, TRAP ? 32'd0 : 32'hFFFFF544);
    end
    runAccess(1'b0, 32'h3, READ_HALF_UNSIGNED, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsLoad !== (TRAP ? 32'd0 : 32'h0000F544)) begin
      nFail++;
      $display("FAIL half_unsigned_0x3: load=%h, required %h", obsLoad, TRAP ? 32'd0 : 32'h0000F544);
    end
    runAccess(1'b0, 32'h3, READ_BYTE_SIGNED, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsCycles != 1 || obsLoad !== 32'h00000044 || obsExc !== 1'b0) begin
      nFail++;
      $display("FAIL byte_signed_0x3: cycles=%0d load=%h exc=%b, required 1 00000044 0",
               obsCycles, obsLoad, obsExc);
    end
  endtask

  task automatic test_plan_store();
    logic [31:0] expAddr;
    runAccess(1'b1, 32'h2, READ_WORD, WRITE_WORD, 32'hAABBCCDD);
    if (!TRAP) modelStore(32'h2, 4, 32'hAABBCCDD);
    nChecks++;
    if (obsCycles != (TRAP ? 1 : 4) || obsExc !== TRAP || obsCode !== (TRAP ? 5'd5 : 5'd0)) begin
      nFail++;
      $display("FAIL store_0x2_cycles: cycles=%0d exc=%b code=%0d, required %0d %b %0d",
               obsCycles, obsExc, obsCode, TRAP ? 1 : 4, TRAP, TRAP ? 5 : 0);
    end
    for (int k = 0; k < obsCycles && k < 4; k++) begin
      expAddr = 32'h2 + 32'(k);
      nChecks++;
      if (obsWe[k] !== !TRAP || (!TRAP && (obsAddr[k] !== expAddr || obsWval[k][7:0] !== 8'(32'hAABBCCDD >> (8 * k)) ||
          obsStall[k] !== (k < 3) || obsWt[k] !== WRITE_BYTE))) begin
        nFail++;
        $display("FAIL store_beat%0d: we=%b addr=%h val=%h stall=%b, required we=%b addr=%h val=%h stall=%b",
                 k, obsWe[k], obsAddr[k], obsWval[k][7:0], obsStall[k], !TRAP, expAddr,
                 8'(32'hAABBCCDD >> (8 * k)), k < 3);
      end
    end
    nChecks++;
    if (memWord(0) !== (TRAP ? 32'h44332211 : 32'hCCDD2211) || memWord(1) !== (TRAP ? 32'h887766F5 : 32'h8877AABB)) begin
      nFail++;
      $display("FAIL store_0x2_memory: w0=%h w1=%h, required %h %h", memWord(0), memWord(1),
               TRAP ? 32'h44332211 : 32'hCCDD2211, TRAP ? 32'h887766F5 : 32'h8877AABB);
    end
    runAccess(1'b1, 32'h6, READ_WORD, WRITE_WORD, 32'h01020304);
    if (!TRAP) modelStore(32'h6, 4, 32'h01020304);
    nChecks++;
    if (obsExc !== TRAP || obsCode !== (TRAP ? 5'd5 : 5'd0) || obsWe[0] !== !TRAP || obsCycles != (TRAP ? 1 : 4)) begin
      nFail++;
      $display("FAIL store_0x6: exc=%b code=%0d we=%b cycles=%0d, required %b %0d %b %0d",
               obsExc, obsCode, obsWe[0], obsCycles, TRAP, TRAP ? 5 : 0, !TRAP, TRAP ? 1 : 4);
    end
  endtask

  task automatic test_reset_mid_store();
`ifndef UNALIGNED_TRAP_EN
    preload();
    reqValid = 1'b1; reqLoad = 1'b0; reqWriteEnable = 1'b1; reqAddress = 32'h2;
    reqWriteType = WRITE_WORD; reqReadType = READ_WORD; reqWriteValue = 32'hAABBCCDD;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    nChecks++;
    if (memWriteEnable !== 1'b0 || stall !== 1'b0) begin
      nFail++;
      $display("FAIL reset_mid_store_outputs: we=%b stall=%b, required 0 0", memWriteEnable, stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    reqValid = 1'b0; reqWriteEnable = 1'b0;
    modelStore(32'h2, 2, 32'h0000CCDD);
    @(posedge clock);
    #1;
    nChecks++;
    if (memWord(0) !== 32'hCCDD2211 || memWord(1) !== 32'h887766F5) begin
      nFail++;
      $display("FAIL reset_mid_store_memory: w0=%h w1=%h, required CCDD2211 887766F5", memWord(0), memWord(1));
    end
`endif
  endtask

  task automatic test_wrap();
    runAccess(1'b0, 32'hFFFFFFFF, READ_WORD, WRITE_BYTE, 32'd0);
    nChecks++;
    if (obsLoad !== (TRAP ? 32'd0 : modelLoad(32'hFFFFFFFF, READ_WORD)) ||
        (!TRAP && (obsAddr[0] !== 32'hFFFFFFFC || obsAddr[1] !== 32'h00000000))) begin
      nFail++;
      $display("FAIL wrap_load: load=%h a0=%h a1=%h, required load=%h a0=FFFFFFFC a1=00000000",
               obsLoad, obsAddr[0], obsAddr[1], TRAP ? 32'd0 : modelLoad(32'hFFFFFFFF, READ_WORD));
    end
    runAccess(1'b1, 32'hFFFFFFFE, READ_WORD, WRITE_WORD, 32'h5A6B7C8D);
    if (!TRAP) modelStore(32'hFFFFFFFE, 4, 32'h5A6B7C8D);
    nChecks++;
    if (!TRAP && (obsAddr[2] !== 32'h0 || obsAddr[3] !== 32'h1 || obsWval[3][7:0] !== 8'h5A)) begin
      nFail++;
      $display("FAIL wrap_store: a2=%h a3=%h v3=%h, required 00000000 00000001 5a",
               obsAddr[2], obsAddr[3], obsWval[3][7:0]);
    end
  endtask

  task automatic test_random();
    bit          st;
    logic [31:0] addr;
    logic [31:0] wv;
    read_type_t  rt;
    write_type_t wt;
    int          size;
    bit          mis;
    logic [31:0] expLoad;
    for (int n = 0; n < 60; n++) begin
      st   = 1'($urandom_range(0, 1));
      addr = $urandom;
      rt   = read_type_t'(3'($urandom_range(0, 4)));
      wt   = write_type_t'(2'($urandom_range(0, 2)));
      wv   = $urandom;
      size = accessSize(st, rt, wt);
      mis  = misaligned(addr, size);
      expLoad = (mis && TRAP) ? 32'd0 : modelLoad(addr, rt);
      runAccess(st, addr, rt, wt, wv);
      if (st && !(mis && TRAP)) modelStore(addr, size, wv);
      nChecks++;
      if (obsCycles != modelCycles(st, addr, size) || obsExc !== (mis && TRAP) ||
          obsCode !== ((mis && TRAP) ? (st ? 5'd5 : 5'd4) : 5'd0) || obsPc !== reqPc) begin
        nFail++;
        $display("FAIL rand%0d_control: st=%b addr=%h size=%0d cycles=%0d exc=%b code=%0d, required cycles=%0d exc=%b",
                 n, st, addr, size, obsCycles, obsExc, obsCode, modelCycles(st, addr, size), mis && TRAP);
      end
      if (!st) begin
        nChecks++;
        if (obsLoad !== expLoad) begin
          nFail++;
          $display("FAIL rand%0d_load: addr=%h type=%0d load=%h, required %h", n, addr, rt, obsLoad, expLoad);
        end
      end
    end
    for (int w = 0; w < 16; w++) begin
      nChecks++;
      if (memWord(w) !== {refMem[4 * w + 3], refMem[4 * w + 2], refMem[4 * w + 1], refMem[4 * w]}) begin
        nFail++;
        $display("FAIL rand_memory_word%0d: %h, required %h", w, memWord(w),
                 {refMem[4 * w + 3], refMem[4 * w + 2], refMem[4 * w + 1], refMem[4 * w]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_loads();
    test_plan_store();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
